// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing the register-file write port between two writeback sources
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ValidA,
  output logic                  ReadyA,
  input  logic [REG_BITS-1:0]   RegA,
  input  logic [DATA_WIDTH-1:0] DataA,
  input  logic                  ValidB,
  output logic                  ReadyB,
  input  logic [REG_BITS-1:0]   RegB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  RegWrite,
  output logic [REG_BITS-1:0]   WriteReg,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  MuxSel,
  output logic                  StallA,
  output logic                  StallB,
  output logic [7:0]            DropCount
);
  typedef enum logic {PRI_A, PRI_B} pri_e;
  pri_e pri_q;
  logic grant_a, grant_b, xfer;
  logic reg_write_q, mux_sel_q;
  logic [REG_BITS-1:0] write_reg_q, reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, data_d;
  logic [7:0] drop_q;
  always_comb begin
    grant_a = Rst && ValidA && (!ValidB || pri_q == PRI_A);
    grant_b = Rst && ValidB && !grant_a;
    xfer = grant_a || grant_b;
    reg_d = grant_b ? RegB : RegA;
    data_d = grant_b ? DataB : DataA;
  end
  assign ReadyA = grant_a;
  assign ReadyB = grant_b;
  assign StallA = Rst && ValidA && !grant_a;
  assign StallB = Rst && ValidB && !grant_b;
  assign RegWrite = reg_write_q;
  assign WriteReg = write_reg_q;
  assign WriteData = write_data_q;
  assign MuxSel = mux_sel_q;
  assign DropCount = drop_q;
  // Register-0 writes are accepted so the source retires, but never reach the register file.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pri_q <= PRI_A;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      mux_sel_q <= 1'b0;
      drop_q <= '0;
    end else begin
      reg_write_q <= xfer && reg_d != '0;
      if (xfer) begin
        write_reg_q <= reg_d;
        write_data_q <= data_d;
        mux_sel_q <= grant_b;
        pri_q <= grant_a ? PRI_B : PRI_A;
      end
      if (xfer && reg_d == '0 && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU/execute result) and B (load/multicycle result).
- Performs round-robin arbitration over a valid/ready handshake and registers the winning destination register, data and write enable.
- Drives the select of the 5-bit 2:1 destination-register mux.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_WIDTH, 32, width of writeback data
REG_BITS, 5, width of register address (fixed to the 5-bit mux)

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  reset, asynchronous, active-low
ValidA  input  1  requester A has a write pending
ReadyA  output  1  A's write accepted this cycle (combinational)
RegA  input  REG_BITS  A destination register
DataA  input  DATA_WIDTH  A write data
ValidB  input  1  requester B has a write pending
ReadyB  output  1  B's write accepted this cycle (combinational)
RegB  input  REG_BITS  B destination register
DataB  input  DATA_WIDTH  B write data
RegWrite  output  1  register-file write enable (registered)
WriteReg  output  REG_BITS  register-file write address (registered)
WriteData  output  DATA_WIDTH  register-file write data (registered)
MuxSel  output  1  destination-mux select: 0=A, 1=B (registered)
StallA  output  1  ValidA high and not granted this cycle
StallB  output  1  ValidB high and not granted this cycle
DropCount  output  8  count of accepted writes to register 0, saturating

Behaviour:
- Reset (Rst=0, asynchronous):
  - RegWrite=0, WriteReg=0, WriteData=0, MuxSel=0, DropCount=0.
  - Priority FSM goes to PRI_A.
  - ReadyA, ReadyB, StallA and StallB are all low while Rst=0.
- Priority FSM has two states: PRI_A (A wins ties) and PRI_B (B wins ties).
  - After a grant to A, next state is PRI_B.
  - After a grant to B, next state is PRI_A.
  - With no grant, the state holds.
- Grant, combinational in cycle t:
  - Only ValidA: ReadyA=1.
  - Only ValidB: ReadyB=1.
  - Both valid: the requester favoured by the current state gets Ready; the other gets Stall=1.
  - At most one Ready per cycle. Ready is never asserted without the matching Valid.
- A transfer occurs when Valid&Ready are both high at the rising edge.
- Writeback, registered, 1-cycle latency: on a transfer in cycle t, in cycle t+1:
  - WriteReg=RegX, WriteData=DataX, MuxSel=X.
  - RegWrite=1 unless RegX==0.
- Register-0 writes:
  - The transfer is accepted (Ready=1) but RegWrite=0.
  - DropCount increments, saturating at 255.
- No transfer in cycle t: RegWrite=0 in t+1. WriteReg, WriteData and MuxSel hold their previous values.
- Requester obligations, checked with assertions in the bench:
  - Requesters hold Valid, Reg and Data stable while stalled.
  - The arbiter does not buffer a stalled request.
- Same destination from both requesters in one cycle: no merging. Two sequential writes occur in round-robin order, and the later grant's data is the final register value.
- Back-to-back: if both requesters stay valid, grants strictly alternate A,B,A,B starting from the current state. Sustained throughput is one write per cycle.
- Reset asserted mid-operation:
  - Outputs clear immediately; an in-flight registered write is discarded (RegWrite=0).
  - Priority returns to PRI_A.
  - Transfers presented in the cycle reset deasserts are evaluated normally at the next edge.

Test Plan:
- Reset release, ValidA=ValidB=0 for 5 cycles -> RegWrite=0, all outputs 0, DropCount=0, no Ready.
- ValidA=1, RegA=8, DataA=0x0000_00AA for 1 cycle -> ReadyA=1 same cycle; next cycle RegWrite=1, WriteReg=8, WriteData=0xAA, MuxSel=0.
- From reset, both valid for 4 cycles (RegA=3/DataA=0x11, RegB=4/DataB=0x22) -> grant order A,B,A,B, so WriteReg sequence 3,4,3,4 and MuxSel 0,1,0,1. StallB=1 in cycles 1 and 3, StallA=1 in cycles 2 and 4.
- Both valid with RegA=RegB=9 (DataA=5, DataB=7) from PRI_A -> WriteData 5 then 7 on consecutive cycles, and the final value of reg 9 is 7.
- ValidB=1, RegB=0 for 300 accepted cycles -> ReadyB=1 each cycle, RegWrite stays 0, DropCount saturates at 255.
- Grant to A at cycle t, Rst=0 pulsed asynchronously before edge t+1 -> RegWrite=0, MuxSel=0 immediately; after release, both valid -> A granted first.
